// File: rtl/datapath_seq_core.sv
// ARC-style datapath: register bank with constant registers, instruction register with field
// decode, PSR-style flags and a sequenced ALU with a serial right shifter.
module datapath_seq_core #(
  parameter int unsigned DATAWIDTH_BUS           = 32,
  parameter int unsigned DATAWIDTH_SELECTION     = 6,
  parameter int unsigned NUM_REGS                = 38,
  parameter int unsigned DATAWIDTH_ALU_SELECTION = 4,
  parameter int unsigned DATAWIDTH_DECODEROP     = 8,
  parameter int unsigned REGFIXED_ADDR_0         = 36,
  parameter int unsigned REGFIXED_ADDR_1         = 37,
  parameter int unsigned DATA_REGFIXED_INIT_0    = 9,
  parameter int unsigned DATA_REGFIXED_INIT_1    = 15
) (
  input  logic                               DATAPATH_CLOCK_50,
  input  logic                               DATAPATH_ResetInHigh_In,
  input  logic [DATAWIDTH_BUS-1:0]           DATAPATH_MemoryData_InBUS,
  input  logic [DATAWIDTH_SELECTION-1:0]     DATAPATH_DirA_InBus,
  input  logic [DATAWIDTH_SELECTION-1:0]     DATAPATH_DirB_InBus,
  input  logic [DATAWIDTH_SELECTION-1:0]     DATAPATH_DirC_InBus,
  input  logic                               DATAPATH_SelectA_In,
  input  logic                               DATAPATH_SelectB_In,
  input  logic                               DATAPATH_SelectC_In,
  input  logic                               DATAPATH_RD_In,
  input  logic                               DATAPATH_WriteEn_In,
  input  logic                               DATAPATH_IRLoad_In,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] DATAPATH_ALUOp_InBus,
  input  logic                               DATAPATH_Start_In,
  output logic [DATAWIDTH_BUS-1:0]           DATAPATH_A_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]           DATAPATH_B_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]           DATAPATH_C_OutBUS,
  output logic                               DATAPATH_Busy_Out,
  output logic                               DATAPATH_Done_Out,
  output logic [DATAWIDTH_DECODEROP-1:0]     DATAPATH_DecodeOP_OutBus,
  output logic                               DATAPATH_IR13_Out,
  output logic                               DATAPATH_ConditionCode_Out,
  output logic                               DATAPATH_FlagNegative_Out,
  output logic                               DATAPATH_FlagZero_Out,
  output logic                               DATAPATH_FlagOverflow_Out,
  output logic                               DATAPATH_FlagCarry_Out
);

  localparam int unsigned W  = DATAWIDTH_BUS;
  localparam int unsigned SW = DATAWIDTH_SELECTION;

  localparam int unsigned OpAndcc = 0, OpOrcc = 1, OpNorcc = 2, OpAddcc = 3, OpSrl = 4;
  localparam int unsigned OpAnd = 5, OpOr = 6, OpNor = 7, OpAdd = 8, OpLshift2 = 9;
  localparam int unsigned OpLshift10 = 10, OpSimm13 = 11, OpSext13 = 12, OpInc = 13;
  localparam int unsigned OpIncpc = 14, OpRshift5 = 15;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   regs_q [NUM_REGS];
  logic [31:0]    ir_q, mem_ir;
  logic [W-1:0]   result_q, shift_q;
  logic [4:0]     cnt_q, shamt;
  logic           flag_n_q, flag_z_q, flag_v_q, flag_c_q;
  logic [SW-1:0]  addr_a, addr_b, addr_c;
  logic [W-1:0]   a_data, b_data, c_bus, alu_res;
  logic [W:0]     sum_ext;
  logic [31:0]    alu_op;
  logic           alu_v, alu_c, alu_setcc, reg_wr, cond;

  assign mem_ir = 32'(DATAPATH_MemoryData_InBUS);
  assign alu_op = 32'(DATAPATH_ALUOp_InBus);

  assign addr_a = DATAPATH_SelectA_In ? SW'(ir_q[18:14]) : DATAPATH_DirA_InBus;
  assign addr_b = DATAPATH_SelectB_In ? SW'(ir_q[4:0])   : DATAPATH_DirB_InBus;
  assign addr_c = DATAPATH_SelectC_In ? SW'(ir_q[29:25]) : DATAPATH_DirC_InBus;

  assign a_data = (addr_a != '0 && int'(addr_a) < NUM_REGS) ? regs_q[int'(addr_a)] : '0;
  assign b_data = (addr_b != '0 && int'(addr_b) < NUM_REGS) ? regs_q[int'(addr_b)] : '0;
  assign c_bus  = DATAPATH_RD_In ? DATAPATH_MemoryData_InBUS : result_q;

  // Register 0 and the constant registers are read-only.
  assign reg_wr = DATAPATH_WriteEn_In && addr_c != '0 && int'(addr_c) < NUM_REGS &&
                  int'(addr_c) != REGFIXED_ADDR_0 && int'(addr_c) != REGFIXED_ADDR_1;

  assign shamt     = b_data[4:0];
  assign sum_ext   = {1'b0, a_data} + {1'b0, b_data};
  assign alu_setcc = alu_op <= OpAddcc;

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (alu_op)
      OpAndcc, OpAnd: alu_res = a_data & b_data;
      OpOrcc, OpOr:   alu_res = a_data | b_data;
      OpNorcc, OpNor: alu_res = ~(a_data | b_data);
      OpAddcc, OpAdd: begin
        alu_res = sum_ext[W-1:0];
        alu_c   = sum_ext[W];
        alu_v   = (a_data[W-1] == b_data[W-1]) && (sum_ext[W-1] != a_data[W-1]);
      end
      OpSrl:      alu_res = a_data;
      OpLshift2:  alu_res = a_data << 2;
      OpLshift10: alu_res = a_data << 10;
      OpSimm13:   alu_res = {{(W-13){1'b0}}, ir_q[12:0]};
      OpSext13:   alu_res = {{(W-13){ir_q[12]}}, ir_q[12:0]};
      OpInc:      alu_res = a_data + W'(1);
      OpIncpc:    alu_res = a_data + W'(4);
      OpRshift5:  alu_res = $unsigned($signed(a_data) >>> 5);
      default:    alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (DATAPATH_Start_In) begin
          state_d = (alu_op == OpSrl && shamt != '0) ? StShift : StDone;
        end
      end
      StShift: if (cnt_q == 5'd1) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge DATAPATH_CLOCK_50) begin
    if (DATAPATH_ResetInHigh_In) begin
      state_q  <= StIdle;
      ir_q     <= '0;
      result_q <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_v_q <= 1'b0;
      flag_c_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == REGFIXED_ADDR_0)      regs_q[i] <= W'(DATA_REGFIXED_INIT_0);
        else if (i == REGFIXED_ADDR_1) regs_q[i] <= W'(DATA_REGFIXED_INIT_1);
        else                           regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (DATAPATH_IRLoad_In) ir_q <= mem_ir;
      if (reg_wr) regs_q[int'(addr_c)] <= c_bus;
      case (state_q)
        StIdle: begin
          if (DATAPATH_Start_In) begin
            if (alu_op == OpSrl && shamt != '0) begin
              shift_q <= a_data;
              cnt_q   <= shamt;
            end else begin
              result_q <= alu_res;
              if (alu_setcc) begin
                flag_n_q <= alu_res[W-1];
                flag_z_q <= (alu_res == '0);
                flag_v_q <= alu_v;
                flag_c_q <= alu_c;
              end
            end
          end
        end
        StShift: begin
          // The result register only changes once the final shift lands.
          shift_q <= shift_q >> 1;
          cnt_q   <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) result_q <= shift_q >> 1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (ir_q[28:25])
      4'b0001: cond = flag_z_q;
      4'b0101: cond = flag_c_q;
      4'b0110: cond = flag_n_q;
      4'b0111: cond = flag_v_q;
      4'b1000: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign DATAPATH_A_OutBUS          = a_data;
  assign DATAPATH_B_OutBUS          = b_data;
  assign DATAPATH_C_OutBUS          = result_q;
  assign DATAPATH_Busy_Out          = (state_q != StIdle);
  assign DATAPATH_Done_Out          = (state_q == StDone);
  assign DATAPATH_DecodeOP_OutBus   = DATAWIDTH_DECODEROP'({ir_q[31:30], ir_q[24:19]});
  assign DATAPATH_IR13_Out          = ir_q[13];
  assign DATAPATH_ConditionCode_Out = cond;
  assign DATAPATH_FlagNegative_Out  = flag_n_q;
  assign DATAPATH_FlagZero_Out      = flag_z_q;
  assign DATAPATH_FlagOverflow_Out  = flag_v_q;
  assign DATAPATH_FlagCarry_Out     = flag_c_q;

endmodule
